// File: rtl/l1_mem_responder.sv
// l1_mem_responder: in-order TileLink-style A/D responder over a block-organised backing SRAM.
// Optional macro L1_MEM_RSP_ZERO_INIT_EN enables a post-reset zero-fill sweep of the store.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DCACHE_BLOCKWORDS
`define DCACHE_BLOCKWORDS 8
`endif
`ifndef BYTESOFWORD
`define BYTESOFWORD 4
`endif
`ifndef D_SOURCE
`define D_SOURCE 8
`endif

module l1_mem_responder #(
   parameter int MEM_DEPTH      = 256,
   parameter int LATENCY        = 4,
   parameter int RSP_FIFO_DEPTH = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      mem_req_valid_i,
   output logic                                      mem_req_ready_o,
   input  logic [2:0]                                mem_req_a_opcode_i,
   input  logic [2:0]                                mem_req_a_param_i,
   input  logic [`XLEN-1:0]                          mem_req_a_addr_i,
   input  logic [`DCACHE_BLOCKWORDS*`XLEN-1:0]       mem_req_a_data_i,
   input  logic [`DCACHE_BLOCKWORDS*`BYTESOFWORD-1:0] mem_req_a_mask_i,
   input  logic [`D_SOURCE-1:0]                      mem_req_a_source_i,
   input  logic                                      mem_rsp_ready_i,
   output logic                                      mem_rsp_valid_o,
   output logic [2:0]                                mem_rsp_d_opcode_o,
   output logic [`XLEN-1:0]                          mem_rsp_d_addr_o,
   output logic [`DCACHE_BLOCKWORDS*`XLEN-1:0]       mem_rsp_d_data_o,
   output logic [`D_SOURCE-1:0]                      mem_rsp_d_source_o
);
   localparam int BLK_BITS  = `DCACHE_BLOCKWORDS * `XLEN;
   localparam int BLK_BYTES = `DCACHE_BLOCKWORDS * `BYTESOFWORD;
   localparam int OFS_W     = $clog2(BLK_BYTES);
   localparam int IDX_W     = $clog2(MEM_DEPTH);
   localparam int CNT_W     = $clog2(RSP_FIFO_DEPTH + 1);
   localparam int PTR_W     = $clog2(RSP_FIFO_DEPTH);

   typedef struct packed {
      logic [2:0]           opcode;
      logic [`XLEN-1:0]     addr;
      logic [BLK_BITS-1:0]  data;
      logic [`D_SOURCE-1:0] source;
   } rsp_t;

   logic [BLK_BITS-1:0] mem [MEM_DEPTH];
   logic [IDX_W-1:0]    req_idx;
   logic                accept;
   logic                is_get;
   logic                is_put;
   logic                init_done;
   rsp_t                new_rsp;
   logic                unused_ok;

   assign req_idx   = mem_req_a_addr_i[OFS_W +: IDX_W];
   assign accept    = mem_req_valid_i & mem_req_ready_o;
   assign is_get    = (mem_req_a_opcode_i == 3'd4);
   assign is_put    = (mem_req_a_opcode_i == 3'd0) || (mem_req_a_opcode_i == 3'd1);
   assign unused_ok = ^mem_req_a_param_i;

   always_comb begin
      new_rsp        = '0;
      new_rsp.opcode = is_get ? 3'd1 : 3'd0;
      new_rsp.addr   = mem_req_a_addr_i;
      new_rsp.data   = is_get ? mem[req_idx] : '0;
      new_rsp.source = mem_req_a_source_i;
   end

`ifdef L1_MEM_RSP_ZERO_INIT_EN
   logic             init_busy;
   logic [IDX_W-1:0] init_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         init_busy <= 1'b1;
         init_idx  <= '0;
      end else if (init_busy) begin
         init_idx <= init_idx + IDX_W'(1);
         if (init_idx == IDX_W'(MEM_DEPTH - 1))
            init_busy <= 1'b0;
      end
   end
   assign init_done = !init_busy;
`else
   assign init_done = 1'b1;
`endif

   // Writes land on the accept edge, so a Get accepted next cycle reads the new bytes.
   always_ff @(posedge clk) begin
`ifdef L1_MEM_RSP_ZERO_INIT_EN
      if (!rst && init_busy)
         mem[init_idx] <= '0;
`endif
      if (accept && is_put) begin
         for (int b = 0; b < BLK_BYTES; b++) begin
            if (mem_req_a_mask_i[b])
               mem[req_idx][b*8 +: 8] <= mem_req_a_data_i[b*8 +: 8];
         end
      end
   end

   // The FIFO write is the last latency stage, so only LATENCY-1 registers sit in front of it.
   logic fifo_wr;
   rsp_t fifo_wdat;

   if (LATENCY > 1) begin : g_pipe
      logic stg_vld [LATENCY-1];
      rsp_t stg_dat [LATENCY-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < LATENCY - 1; i++)
               stg_vld[i] <= 1'b0;
         end else begin
            stg_vld[0] <= accept;
            for (int i = 1; i < LATENCY - 1; i++)
               stg_vld[i] <= stg_vld[i-1];
         end
         stg_dat[0] <= new_rsp;
         for (int i = 1; i < LATENCY - 1; i++)
            stg_dat[i] <= stg_dat[i-1];
      end
      assign fifo_wr   = stg_vld[LATENCY-2];
      assign fifo_wdat = stg_dat[LATENCY-2];
   end else begin : g_nopipe
      assign fifo_wr   = accept;
      assign fifo_wdat = new_rsp;
   end

   rsp_t             fifo_mem [RSP_FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   logic [CNT_W-1:0] outstanding;
   logic             d_fire;
   rsp_t             head;

   assign d_fire = mem_rsp_valid_o & mem_rsp_ready_i;
   assign head   = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_wr) begin
            fifo_mem[wr_ptr] <= fifo_wdat;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (d_fire)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({fifo_wr, d_fire})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Counting from accept (not FIFO entry) reserves a slot for everything still in the pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({accept, d_fire})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   assign mem_req_ready_o    = !rst && init_done && (outstanding < CNT_W'(RSP_FIFO_DEPTH));
   assign mem_rsp_valid_o    = (fifo_cnt != '0);
   assign mem_rsp_d_opcode_o = mem_rsp_valid_o ? head.opcode : 3'd0;
   assign mem_rsp_d_addr_o   = mem_rsp_valid_o ? head.addr   : '0;
   assign mem_rsp_d_data_o   = mem_rsp_valid_o ? head.data   : '0;
   assign mem_rsp_d_source_o = mem_rsp_valid_o ? head.source : '0;

endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed bench for l1_mem_responder: a queue/array reference model checked every cycle,
// plus literal expectations on selected responses (XLEN=32, 8 words per block, 4 bytes per word).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DCACHE_BLOCKWORDS
`define DCACHE_BLOCKWORDS 8
`endif
`ifndef BYTESOFWORD
`define BYTESOFWORD 4
`endif
`ifndef D_SOURCE
`define D_SOURCE 8
`endif

module tb_l1_mem_responder;
   localparam int LAT  = 4;
   localparam int DEP  = 4;
   localparam int MEMD = 256;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready;
   logic [2:0]   req_opcode, req_param;
   logic [31:0]  req_addr;
   logic [255:0] req_data;
   logic [31:0]  req_mask;
   logic [7:0]   req_source;
   logic         rsp_ready, rsp_valid;
   logic [2:0]   rsp_opcode;
   logic [31:0]  rsp_addr;
   logic [255:0] rsp_data;
   logic [7:0]   rsp_source;

   always #5 clk = ~clk;

   l1_mem_responder #(.MEM_DEPTH(MEMD), .LATENCY(LAT), .RSP_FIFO_DEPTH(DEP)) dut (
      .clk(clk), .rst(rst),
      .mem_req_valid_i(req_valid), .mem_req_ready_o(req_ready),
      .mem_req_a_opcode_i(req_opcode), .mem_req_a_param_i(req_param),
      .mem_req_a_addr_i(req_addr), .mem_req_a_data_i(req_data),
      .mem_req_a_mask_i(req_mask), .mem_req_a_source_i(req_source),
      .mem_rsp_ready_i(rsp_ready), .mem_rsp_valid_o(rsp_valid),
      .mem_rsp_d_opcode_o(rsp_opcode), .mem_rsp_d_addr_o(rsp_addr),
      .mem_rsp_d_data_o(rsp_data), .mem_rsp_d_source_o(rsp_source)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // Reference model: expected responses in acceptance order, each usable from accept+LAT.
   typedef struct {
      logic [2:0]   op;
      logic [31:0]  addr;
      logic [255:0] data;
      logic [7:0]   src;
      int           avail;
      bit           known;
   } exp_t;

   exp_t         expq[$];
   logic [255:0] mmem   [MEMD];
   bit           mknown [MEMD];
   int           init_left = 0;

   int           acc_cyc  [256];
   int           fire_cyc [256];
   logic [2:0]   f_op     [256];
   logic [31:0]  f_addr   [256];
   logic [255:0] f_data   [256];
   int           fire_seq [$];

   initial for (int i = 0; i < 256; i++) begin acc_cyc[i] = -1; fire_cyc[i] = -1; end

   task automatic model_accept();
      exp_t e;
      int   idx;
      idx     = int'((req_addr >> 5) % MEMD);
      e.addr  = req_addr;
      e.src   = req_source;
      e.avail = cyc + LAT;
      e.known = 1'b1;
      e.op    = 3'd0;
      e.data  = '0;
      if (req_opcode == 3'd4) begin
         e.op    = 3'd1;
         e.data  = mmem[idx];
         e.known = mknown[idx];
      end else if (req_opcode == 3'd0 || req_opcode == 3'd1) begin
         for (int b = 0; b < 32; b++)
            if (req_mask[b]) mmem[idx][b*8 +: 8] = req_data[b*8 +: 8];
         if (req_mask == 32'hFFFF_FFFF) mknown[idx] = 1'b1;
      end
      acc_cyc[req_source] = cyc;
      expq.push_back(e);
   endtask

   logic [298:0] prev_d;
   logic [298:0] cur_d;
   bit           prev_stall = 1'b0;
   bit           exp_vld, exp_rdy;

   always @(negedge clk) begin
      if (rst) begin
         chk("ready_in_reset", req_ready, 1'b0);
         expq.delete();
         prev_stall = 1'b0;
`ifdef L1_MEM_RSP_ZERO_INIT_EN
         init_left = MEMD;
         for (int i = 0; i < MEMD; i++) begin mmem[i] = '0; mknown[i] = 1'b1; end
`endif
      end else begin
         cur_d = {rsp_opcode, rsp_addr, rsp_data, rsp_source};
         if (prev_stall) chk("d_hold", cur_d, prev_d);
         exp_rdy = (init_left == 0) && (expq.size() < DEP);
         chk("a_ready", req_ready, exp_rdy);
         exp_vld = (expq.size() > 0) && (expq[0].avail <= cyc);
         chk("d_valid", rsp_valid, exp_vld);
         if (exp_vld) begin
            chk("d_opcode", rsp_opcode, expq[0].op);
            chk("d_addr", rsp_addr, expq[0].addr);
            chk("d_source", rsp_source, expq[0].src);
            if (expq[0].known) chk("d_data", rsp_data, expq[0].data);
         end else if (!rsp_valid) begin
            chk("d_idle_zero", cur_d, '0);
         end
         if (rsp_valid && rsp_ready) begin
            fire_cyc[rsp_source] = cyc;
            f_op[rsp_source]     = rsp_opcode;
            f_addr[rsp_source]   = rsp_addr;
            f_data[rsp_source]   = rsp_data;
            fire_seq.push_back(int'(rsp_source));
            if (expq.size() > 0) void'(expq.pop_front());
         end
         if (req_valid && req_ready) model_accept();
         if (init_left > 0) init_left--;
         prev_stall = rsp_valid && !rsp_ready;
         prev_d     = cur_d;
      end
   end

   function automatic logic [255:0] blk_seq(input logic [31:0] base);
      logic [255:0] b;
      for (int i = 0; i < 8; i++) b[i*32 +: 32] = base + 32'(i);
      return b;
   endfunction

   task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [255:0] d,
                          input logic [31:0] m, input logic [7:0] s);
      req_opcode = op; req_addr = a; req_data = d; req_mask = m; req_source = s;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [255:0] d,
                        input logic [31:0] m, input logic [7:0] s);
      bit acc;
      acc = 1'b0;
      set_req(op, a, d, m, s);
      req_valid = 1'b1;
      for (int i = 0; i < 2000 && !acc; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_chk++;
         $display("FAIL accept_timeout: source %h not accepted, want accept within 2000 cycles", s);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (expq.size() == 0) break;
      end
      if (expq.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d responses pending, want 0", expq.size());
      end
   endtask

   logic [255:0] exp_part;
   int           k, rdy_rise, s;
   bit           acc;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_param = 3'd7; rsp_ready = 1'b1;
      set_req(3'd4, '0, '0, '0, '0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // PutFull then Get of the same block.
      issue(3'd0, 32'h40, blk_seq(32'h1000), 32'hFFFF_FFFF, 8'h13);
      issue(3'd4, 32'h44, '0, '0, 8'h05);
      req_valid = 1'b0;
      drain();
      chk("lit_put_opcode", f_op[8'h13], 3'd0);
      chk("lit_put_addr", f_addr[8'h13], 32'h40);
      chk("lit_put_latency", fire_cyc[8'h13] - acc_cyc[8'h13], 4);
      chk("lit_get_opcode", f_op[8'h05], 3'd1);
      chk("lit_get_addr", f_addr[8'h05], 32'h44);
      chk("lit_get_data", f_data[8'h05], blk_seq(32'h1000));

      // PutPartial on word 0, re-read directly and through an aliased address.
      exp_part = blk_seq(32'h1000);
      exp_part[31:0] = 32'hDEAD_BEEF;
      issue(3'd1, 32'h40, {224'h0, 32'hDEAD_BEEF}, 32'h0000_000F, 8'h30);
      issue(3'd4, 32'h40, '0, '0, 8'h31);
      issue(3'd4, 32'h2040, '0, '0, 8'h32);
      // Unknown opcode must not touch memory.
      issue(3'd0, 32'h60, blk_seq(32'h2000), 32'hFFFF_FFFF, 8'h33);
      issue(3'd2, 32'h60, blk_seq(32'h9999), 32'hFFFF_FFFF, 8'h34);
      issue(3'd4, 32'h60, '0, '0, 8'h35);
      req_valid = 1'b0;
      drain();
      chk("lit_partial_data", f_data[8'h31], exp_part);
      chk("lit_alias_data", f_data[8'h32], exp_part);
      chk("lit_alias_addr", f_addr[8'h32], 32'h2040);
      chk("lit_badop_opcode", f_op[8'h34], 3'd0);
      chk("lit_badop_data", f_data[8'h34], 256'h0);
      chk("lit_badop_noeffect", f_data[8'h35], blk_seq(32'h2000));

      // Six back-to-back Gets against a stalled D channel: only four fit.
      rsp_ready = 1'b0;
      k = 0;
      set_req(3'd4, 32'h60, '0, '0, 8'h20);
      req_valid = 1'b1;
      repeat (8) begin
         @(negedge clk); acc = req_ready;
         @(posedge clk); #1;
         if (acc) begin k++; set_req(3'd4, 32'h60, '0, '0, 8'(8'h20 + k)); end
      end
      chk("lit_burst_accepted", k, 4);
      chk("lit_burst_full_ready", req_ready, 1'b0);
      rsp_ready = 1'b1;
      rdy_rise = -1;
      for (int i = 0; i < 50 && k < 6; i++) begin
         @(negedge clk); acc = req_ready;
         if (acc && rdy_rise < 0) rdy_rise = cyc;
         @(posedge clk); #1;
         if (acc) begin k++; set_req(3'd4, 32'h60, '0, '0, 8'(8'h20 + k)); end
      end
      req_valid = 1'b0;
      drain();
      chk("lit_ready_rise", rdy_rise, fire_cyc[8'h20] + 1);
      s = fire_seq.size();
      for (int i = 0; i < 6; i++) chk("lit_burst_order", fire_seq[s-6+i], 8'h20 + i);

      // Three-cycle D stall in the middle of a burst.
      for (int i = 0; i < 4; i++) issue(3'd4, 32'h40, '0, '0, 8'(8'h40 + i));
      req_valid = 1'b0;
      @(posedge clk); #1 rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rsp_ready = 1'b1;
      drain();
      s = fire_seq.size();
      for (int i = 0; i < 4; i++) chk("lit_stall_order", fire_seq[s-4+i], 8'h40 + i);
      chk("lit_stall_data", f_data[8'h42], exp_part);

      // Reset with three responses in flight.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(3'd4, 32'h40, '0, '0, 8'(8'h50 + i));
      req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("lit_rst_ready", req_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("lit_rst_valid", rsp_valid, 1'b0);
      @(posedge clk); #1 rst = 1'b0; rsp_ready = 1'b1;
      issue(3'd4, 32'h40, '0, '0, 8'h60);
      req_valid = 1'b0;
      drain();
      chk("lit_rst_dropped", fire_cyc[8'h50], -1);
`ifdef L1_MEM_RSP_ZERO_INIT_EN
      chk("lit_rst_get_data", f_data[8'h60], 256'h0);
`else
      chk("lit_rst_get_data", f_data[8'h60], exp_part);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

endmodule
